vram_port_arbiter: RTL

//   Shares the single-port VRAM/register RAM between the Avalon-MM slave
//   (CPU writes of score/level/lines, CPU readback) and the VGA text fetch path.

---
 rtl/vram_port_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_port_arbiter.sv
//-----------------------------------------------------------------------------
// vram_port_arbiter
//
// Shares one single-port VRAM/register RAM between the Avalon-MM slave
// (CPU writes and readback of score/level/lines) and the VGA text fetch path.
// Video fetches own the port by default; a starvation counter forces a
// pending Avalon access through after STARVE_MAX consecutive denied cycles,
// which bounds CPU latency while the raster is busy.
//
// Exactly one owner per cycle drives the RAM port. Avalon reads are
// pipelined: once the read address is issued the port is released, and the
// returning word is captured when it is due, so video can keep fetching
// while the CPU read is in flight.
//
// Parameters
//   ADDR_W      RAM word address width
//   DATA_W      RAM word width
//   RD_LAT      RAM read latency in cycles (1..3)
//   STARVE_MAX  denied cycles before a pending Avalon access is forced
//
// Ports
//   CLK, RESET                      clock, async active-high reset
//   AVL_CS/READ/WRITE/BYTE_EN       Avalon access qualifiers
//   AVL_ADDR, AVL_WRITEDATA         Avalon address / write data
//   AVL_READDATA, AVL_WAITREQUEST   Avalon read data / stall
//   VID_REQ, VID_ADDR               video fetch request (held until VID_GNT)
//   VID_GNT                         video owns the RAM port this cycle
//   VID_DATA, VID_VALID             fetched word, valid RD_LAT cycles later
//   RAM_ADDR/WREN/BYTEEN/WDATA      shared RAM port
//   RAM_Q                           RAM read data
//
// FSM states
//   state   | meaning
//   IDLE    | accepts a new Avalon access; writes complete in the grant cycle
//   RD_WAIT | Avalon read issued, counting down RAM latency; port free
//   RESP    | read word registered, WAITREQUEST low for one cycle
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module vram_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RESET,

    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [DATA_W-1:0] AVL_WRITEDATA,
    output logic [DATA_W-1:0] AVL_READDATA,
    output logic              AVL_WAITREQUEST,

    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic              VID_GNT,
    output logic [DATA_W-1:0] VID_DATA,
    output logic              VID_VALID,

    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WREN,
    output logic [3:0]        RAM_BYTEEN,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_Q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam int CNT_W = 2;
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    state_t            state, state_nxt;
    logic [STV_W-1:0]  starve, starve_nxt;
    logic [CNT_W-1:0]  rd_cnt, rd_cnt_nxt;
    logic [RD_LAT-1:0] vid_pipe, vid_pipe_nxt;
    logic [DATA_W-1:0] avl_rdata;

    logic acc_req;
    logic pending;
    logic force_avl;
    logic gnt_vid;
    logic gnt_avl;
    logic gnt_wr;
    logic gnt_rd;
    logic rd_due;
    logic resp;

    // Grants are masked while RESET is high so a held VID_REQ or Avalon
    // access cannot show up on the RAM port during reset.
    assign acc_req   = AVL_CS & (AVL_READ | AVL_WRITE);
    assign pending   = ~RESET & acc_req & (state == IDLE);
    assign force_avl = pending & (starve == STV_MAX);
    assign gnt_vid   = ~RESET & VID_REQ & ~force_avl;
    assign gnt_avl   = pending & ~gnt_vid;
    // READ and WRITE both high is treated as a write.
    assign gnt_wr    = gnt_avl & AVL_WRITE;
    assign gnt_rd    = gnt_avl & ~AVL_WRITE;
    // Last RD_WAIT cycle is the one where RAM_Q carries the Avalon word.
    assign rd_due    = (state == RD_WAIT) & (rd_cnt == '0);
    assign resp      = (state == RESP);

    always_comb begin
        state_nxt  = state;
        rd_cnt_nxt = rd_cnt;
        case (state)
            IDLE: begin
                if (gnt_rd) begin
                    state_nxt  = RD_WAIT;
                    rd_cnt_nxt = CNT_LOAD;
                end
            end
            RD_WAIT: begin
                if (rd_cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    rd_cnt_nxt = rd_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        starve_nxt = '0;
        if (pending & ~gnt_avl) begin
            starve_nxt = (starve == STV_MAX) ? starve : starve + STV_W'(1);
        end
    end

    always_comb begin
        RAM_ADDR   = '0;
        RAM_WREN   = 1'b0;
        RAM_BYTEEN = '0;
        RAM_WDATA  = '0;
        if (gnt_vid) begin
            RAM_ADDR = VID_ADDR;
        end else if (gnt_wr) begin
            RAM_ADDR   = AVL_ADDR;
            RAM_WREN   = 1'b1;
            RAM_BYTEEN = AVL_BYTE_EN;
            RAM_WDATA  = AVL_WRITEDATA;
        end else if (gnt_rd) begin
            RAM_ADDR = AVL_ADDR;
        end
    end

    always_comb begin
        AVL_WAITREQUEST = 1'b0;
        if (RESET) begin
            AVL_WAITREQUEST = 1'b1;
        end else if (acc_req) begin
            AVL_WAITREQUEST = ~(gnt_wr | resp);
        end
    end

    // The video pipe is a plain shift register carrying the grant, so
    // back-to-back grants produce back-to-back VID_VALID pulses.
    generate
        if (RD_LAT == 1) begin : g_pipe_single
            assign vid_pipe_nxt = gnt_vid;
        end else begin : g_pipe_multi
            assign vid_pipe_nxt = {vid_pipe[RD_LAT-2:0], gnt_vid};
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            starve    <= '0;
            rd_cnt    <= '0;
            vid_pipe  <= '0;
            avl_rdata <= '0;
        end else begin
            state    <= state_nxt;
            starve   <= starve_nxt;
            rd_cnt   <= rd_cnt_nxt;
            vid_pipe <= vid_pipe_nxt;
            if (rd_due) begin
                avl_rdata <= RAM_Q;
            end
        end
    end

    assign VID_GNT      = gnt_vid;
    assign VID_VALID    = vid_pipe[RD_LAT-1];
    assign VID_DATA     = VID_VALID ? RAM_Q : '0;
    assign AVL_READDATA = avl_rdata;

endmodule
